sal_cmd_sched: RTL and testbench
================================

SAL_CMD_SCHED -- requirements
Module: sal_cmd_sched

Interface
REQ-001 Parameter NUM_BANKS, default 8, number of bank controllers sharing the DFI command bus (4 or 8).
REQ-002 Parameter BA_W, default 3, bank address width; SHALL equal clog2(NUM_BANKS) and be at most `DFI_BA_WIDTH.
REQ-003 clk  in  1  sole clock; every output changes only on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 act_req/rd_req/wr_req/pre_req/ref_req  in  NUM_BANKS each  per-bank command requests.
REQ-006 ra  in  NUM_BANKS x `DRAM_RA_WIDTH  per-bank row address; ca  in  NUM_BANKS x `DRAM_CA_WIDTH  per-bank column address.
REQ-007 act_gnt/rd_gnt/wr_gnt/pre_gnt/ref_gnt  out  NUM_BANKS each  per-bank grants.
REQ-008 t_rrd, t_ccd, t_wtr, t_rtw  in  `T_RRD_WIDTH/`T_CCD_WIDTH/`T_WTR_WIDTH/`T_RTW_WIDTH  quasi-static timing values in clk cycles.
REQ-009 dfi_cke, dfi_cs_n[`DFI_CS_WIDTH], dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_ba[`DFI_BA_WIDTH], dfi_addr[`DFI_ADDR_WIDTH], dfi_odt  out  registered DFI control bus.

Function
REQ-010 Grants SHALL be combinational in the request cycle; at most one grant bit SHALL be high across all grant vectors per cycle, except ref_gnt, which is all banks at once.
REQ-011 The DFI command for a grant SHALL appear on the DFI outputs on the next clk edge (latency 1); otherwise the DFI bus SHALL carry NOP (cs_n=0, ras_n=cas_n=we_n=1).
REQ-012 Encodings {ras_n,cas_n,we_n}: ACT=011, RD=101, WR=100, PRE=010, REF=001.
REQ-013 ACT: addr=ra, ba=bank index; RD/WR: addr=ca with A10=0; PRE: A10=0, ba=bank; REF: ba=0, addr=0.
REQ-014 REF SHALL be granted only when ref_req is high for every bank; REF has priority over all other commands that cycle.
REQ-015 If a bank raises more than one request, priority SHALL be RD > WR > ACT > PRE.
REQ-016 A bank is eligible when its highest-priority request passes timing: ACT requires rrd_cnt==0; RD requires ccd_cnt==0 and wtr_cnt==0; WR requires ccd_cnt==0 and rtw_cnt==0; PRE is always eligible.
REQ-017 Among eligible banks, selection SHALL be round-robin, starting at the bank after the last granted bank; the pointer updates only on a non-REF grant.
REQ-018 On a grant, the counter SHALL load max(t_x,1)-1: ACT loads rrd_cnt; RD/WR load ccd_cnt; WR loads wtr_cnt; RD loads rtw_cnt. The next same-class command is earliest t_x cycles later.
REQ-019 Counters SHALL decrement by 1 per cycle, saturating at 0; a load takes precedence over the decrement in the same cycle.
REQ-020 t_x=0 SHALL behave as t_x=1, allowing back-to-back commands.
REQ-021 A request that is not granted SHALL be ignored; bank controllers hold requests until granted. Request withdrawal is permitted and yields no command.

Reset
REQ-022 During rst: all grants 0; DFI NOP; dfi_cke=0; dfi_odt=0; all counters 0; round-robin pointer selects bank 0 first.
REQ-023 dfi_cke SHALL rise on the first clk edge after rst deasserts; no grant is issued in that first cycle.
REQ-024 Reset mid-operation SHALL abort any pending command; the command is not replayed.

Configuration
REQ-025 Macro SAL_DFI_ODT_EN defined: dfi_odt=1 from the WR command cycle through 4 following cycles (BL8 burst on DDR2), retriggered by further WRs.
REQ-026 Macro SAL_DFI_ODT_EN undefined: dfi_odt is tied 0 and no ODT counter is instantiated.

Structure
REQ-027 Package sal_sched_pkg SHALL hold the command enum (NOP, ACT, RD, WR, PRE, REF), the {ras_n,cas_n,we_n} encoding constants, and the NOP defaults.
REQ-028 Sub-module sal_rr_arbiter (NUM_BANKS-way round-robin: request vector in, one-hot grant out, pointer update on accept) SHALL be instantiated once.

Verification
REQ-029 Bench SHALL cover: t_rrd=4, ACT on bank0 and bank1 in the same cycle -> bank0 ACT granted at cycle 0, bank1 at cycle 4; DFI ACT ba=1 at cycle 5.
REQ-030 Bench SHALL cover: t_ccd=2, t_wtr=6, WR bank2 then RD bank2 -> RD granted 6 cycles after WR; ras/cas/we=101 one cycle later.
REQ-031 Bench SHALL cover: banks 0, 3 and 5 hold RD continuously with t_ccd=1 -> grants rotate 0, 3, 5, 0, ... with no starvation.
REQ-032 Bench SHALL cover: all 8 banks assert ref_req while bank4 requests ACT -> all ref_gnt high, ACT withheld; DFI 001 next cycle.
REQ-033 Bench SHALL cover: rst pulsed while rrd_cnt=3 -> NOP and cke=0 immediately; after release, cke=1 after one edge and ACT granted without waiting for t_rrd.
REQ-034 Bench SHALL cover: with SAL_DFI_ODT_EN defined, WR at cycle 10 -> odt high cycles 11-15; without the macro, odt stays 0.

Source files
------------

// File: rtl/sal_sched_pkg.sv
// rtl/sal_sched_pkg.sv - command enum, DFI encodings, NOP defaults and bus widths for sal_cmd_sched
`ifndef DRAM_RA_WIDTH
`define DRAM_RA_WIDTH 14
`endif
`ifndef DRAM_CA_WIDTH
`define DRAM_CA_WIDTH 10
`endif
`ifndef DFI_ADDR_WIDTH
`define DFI_ADDR_WIDTH 14
`endif
`ifndef DFI_BA_WIDTH
`define DFI_BA_WIDTH 3
`endif
`ifndef DFI_CS_WIDTH
`define DFI_CS_WIDTH 1
`endif
`ifndef T_RRD_WIDTH
`define T_RRD_WIDTH 4
`endif
`ifndef T_CCD_WIDTH
`define T_CCD_WIDTH 4
`endif
`ifndef T_WTR_WIDTH
`define T_WTR_WIDTH 4
`endif
`ifndef T_RTW_WIDTH
`define T_RTW_WIDTH 4
`endif

package sal_sched_pkg;

  localparam int RA_W     = `DRAM_RA_WIDTH;
  localparam int CA_W     = `DRAM_CA_WIDTH;
  localparam int ADDR_W   = `DFI_ADDR_WIDTH;
  localparam int BA_MAX_W = `DFI_BA_WIDTH;
  localparam int CS_W     = `DFI_CS_WIDTH;
  localparam int T_RRD_W  = `T_RRD_WIDTH;
  localparam int T_CCD_W  = `T_CCD_WIDTH;
  localparam int T_WTR_W  = `T_WTR_WIDTH;
  localparam int T_RTW_W  = `T_RTW_WIDTH;
  localparam int A10      = 10;

  // One counter width wide enough for every timing input.
  localparam int CNT_W01 = (T_RRD_W > T_CCD_W) ? T_RRD_W : T_CCD_W;
  localparam int CNT_W23 = (T_WTR_W > T_RTW_W) ? T_WTR_W : T_RTW_W;
  localparam int CNT_W   = (CNT_W01 > CNT_W23) ? CNT_W01 : CNT_W23;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_ACT,
    CMD_RD,
    CMD_WR,
    CMD_PRE,
    CMD_REF
  } cmd_e;

  typedef enum logic {
    ST_CKE_LOW,
    ST_ACTIVE
  } sched_state_e;

  localparam logic [2:0] ENC_NOP = 3'b111;
  localparam logic [2:0] ENC_ACT = 3'b011;
  localparam logic [2:0] ENC_RD  = 3'b101;
  localparam logic [2:0] ENC_WR  = 3'b100;
  localparam logic [2:0] ENC_PRE = 3'b010;
  localparam logic [2:0] ENC_REF = 3'b001;

  localparam logic NOP_CS_N = 1'b0;

  function automatic logic [2:0] cmd_enc(input cmd_e cmd);
    logic [2:0] enc;
    case (cmd)
      CMD_ACT: enc = ENC_ACT;
      CMD_RD:  enc = ENC_RD;
      CMD_WR:  enc = ENC_WR;
      CMD_PRE: enc = ENC_PRE;
      CMD_REF: enc = ENC_REF;
      default: enc = ENC_NOP;
    endcase
    return enc;
  endfunction

  // A timing value of 0 behaves as 1, so both load 0.
  function automatic logic [CNT_W-1:0] t_load(input logic [CNT_W-1:0] t);
    return (t == '0) ? '0 : t - CNT_W'(1);
  endfunction

endpackage

// File: rtl/sal_cmd_sched_if.sv
// rtl/sal_cmd_sched_if.sv - per-bank request/grant bundle plus registered DFI control bus
interface sal_cmd_sched_if #(
  parameter int NUM_BANKS = 8
) ();

  logic [NUM_BANKS-1:0]                          act_req;
  logic [NUM_BANKS-1:0]                          rd_req;
  logic [NUM_BANKS-1:0]                          wr_req;
  logic [NUM_BANKS-1:0]                          pre_req;
  logic [NUM_BANKS-1:0]                          ref_req;
  logic [NUM_BANKS-1:0][sal_sched_pkg::RA_W-1:0] ra;
  logic [NUM_BANKS-1:0][sal_sched_pkg::CA_W-1:0] ca;

  logic [NUM_BANKS-1:0]                          act_gnt;
  logic [NUM_BANKS-1:0]                          rd_gnt;
  logic [NUM_BANKS-1:0]                          wr_gnt;
  logic [NUM_BANKS-1:0]                          pre_gnt;
  logic [NUM_BANKS-1:0]                          ref_gnt;

  logic                                          dfi_cke;
  logic [sal_sched_pkg::CS_W-1:0]                dfi_cs_n;
  logic                                          dfi_ras_n;
  logic                                          dfi_cas_n;
  logic                                          dfi_we_n;
  logic [sal_sched_pkg::BA_MAX_W-1:0]            dfi_ba;
  logic [sal_sched_pkg::ADDR_W-1:0]              dfi_addr;
  logic                                          dfi_odt;

  modport master (
    output act_req, rd_req, wr_req, pre_req, ref_req, ra, ca,
    input  act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt,
    input  dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_ba, dfi_addr, dfi_odt
  );

  modport slave (
    input  act_req, rd_req, wr_req, pre_req, ref_req, ra, ca,
    output act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt,
    output dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_ba, dfi_addr, dfi_odt
  );

endinterface

// File: rtl/sal_rr_arbiter.sv
// rtl/sal_rr_arbiter.sv - N-way round-robin arbiter; search starts one past the last accepted winner
module sal_rr_arbiter #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_i,
  input  logic             accept_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    valid_o   = 1'b0;
    cand      = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IDX_W'((int'(last_q) + i) % N);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_idx_o   = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

  assign last_d = accept_i ? gnt_idx_o : last_q;

  // Reset points at the top bank so bank 0 is searched first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= IDX_W'(N - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/sal_cmd_sched.sv
// rtl/sal_cmd_sched.sv - arbitrates bank commands onto one registered DFI bus with rrd/ccd/wtr/rtw spacing
// SAL_DFI_ODT_EN: drive dfi_odt for the WR command cycle and the 4 cycles after it.
module sal_cmd_sched
  import sal_sched_pkg::*;
#(
  parameter int NUM_BANKS = 8,
  parameter int BA_W      = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [T_RRD_W-1:0] t_rrd,
  input  logic [T_CCD_W-1:0] t_ccd,
  input  logic [T_WTR_W-1:0] t_wtr,
  input  logic [T_RTW_W-1:0] t_rtw,
  sal_cmd_sched_if.slave     bus
);

  sched_state_e          state_q, state_d;
  logic                  cke_q;
  cmd_e                  bank_cmd [NUM_BANKS];
  logic [NUM_BANKS-1:0]  elig;
  logic [NUM_BANKS-1:0]  arb_req;
  logic [NUM_BANKS-1:0]  arb_gnt;
  logic [BA_W-1:0]       arb_idx;
  logic                  arb_valid;
  logic                  ref_all;
  cmd_e                  gnt_cmd;

  logic [CNT_W-1:0]      rrd_cnt_q, rrd_cnt_d;
  logic [CNT_W-1:0]      ccd_cnt_q, ccd_cnt_d;
  logic [CNT_W-1:0]      wtr_cnt_q, wtr_cnt_d;
  logic [CNT_W-1:0]      rtw_cnt_q, rtw_cnt_d;

  logic [2:0]            enc_q, enc_d;
  logic [BA_MAX_W-1:0]   ba_q, ba_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;

  // CKE comes up one edge after reset release; commands wait for it.
  always_comb begin
    state_d = state_q;
    cke_q   = 1'b0;
    case (state_q)
      ST_CKE_LOW: state_d = ST_ACTIVE;
      ST_ACTIVE:  cke_q   = 1'b1;
      default:    state_d = ST_CKE_LOW;
    endcase
  end

  // Only a bank's highest-priority request is considered; it must pass timing itself.
  always_comb begin
    elig = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_cmd[b] = CMD_NOP;
      if (bus.rd_req[b]) begin
        bank_cmd[b] = CMD_RD;
        elig[b]     = (ccd_cnt_q == '0) && (wtr_cnt_q == '0);
      end else if (bus.wr_req[b]) begin
        bank_cmd[b] = CMD_WR;
        elig[b]     = (ccd_cnt_q == '0) && (rtw_cnt_q == '0);
      end else if (bus.act_req[b]) begin
        bank_cmd[b] = CMD_ACT;
        elig[b]     = (rrd_cnt_q == '0);
      end else if (bus.pre_req[b]) begin
        bank_cmd[b] = CMD_PRE;
        elig[b]     = 1'b1;
      end
    end
  end

  assign ref_all = cke_q && (&bus.ref_req);
  assign arb_req = (cke_q && !ref_all) ? elig : '0;

  sal_rr_arbiter #(
    .N     (NUM_BANKS),
    .IDX_W (BA_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (arb_req),
    .accept_i  (arb_valid),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .valid_o   (arb_valid)
  );

  assign gnt_cmd = ref_all   ? CMD_REF :
                   arb_valid ? bank_cmd[arb_idx] : CMD_NOP;

  assign bus.act_gnt = (gnt_cmd == CMD_ACT) ? arb_gnt : '0;
  assign bus.rd_gnt  = (gnt_cmd == CMD_RD)  ? arb_gnt : '0;
  assign bus.wr_gnt  = (gnt_cmd == CMD_WR)  ? arb_gnt : '0;
  assign bus.pre_gnt = (gnt_cmd == CMD_PRE) ? arb_gnt : '0;
  assign bus.ref_gnt = {NUM_BANKS{ref_all}};

  always_comb begin
    rrd_cnt_d = (rrd_cnt_q != '0) ? rrd_cnt_q - CNT_W'(1) : '0;
    ccd_cnt_d = (ccd_cnt_q != '0) ? ccd_cnt_q - CNT_W'(1) : '0;
    wtr_cnt_d = (wtr_cnt_q != '0) ? wtr_cnt_q - CNT_W'(1) : '0;
    rtw_cnt_d = (rtw_cnt_q != '0) ? rtw_cnt_q - CNT_W'(1) : '0;
    case (gnt_cmd)
      CMD_ACT: rrd_cnt_d = t_load(CNT_W'(t_rrd));
      CMD_RD: begin
        ccd_cnt_d = t_load(CNT_W'(t_ccd));
        rtw_cnt_d = t_load(CNT_W'(t_rtw));
      end
      CMD_WR: begin
        ccd_cnt_d = t_load(CNT_W'(t_ccd));
        wtr_cnt_d = t_load(CNT_W'(t_wtr));
      end
      default: ;
    endcase
  end

  always_comb begin
    enc_d  = cmd_enc(gnt_cmd);
    ba_d   = '0;
    addr_d = '0;
    case (gnt_cmd)
      CMD_ACT: begin
        ba_d   = BA_MAX_W'(arb_idx);
        addr_d = ADDR_W'(bus.ra[arb_idx]);
      end
      CMD_RD, CMD_WR: begin
        ba_d        = BA_MAX_W'(arb_idx);
        addr_d      = ADDR_W'(bus.ca[arb_idx]);
        addr_d[A10] = 1'b0;
      end
      CMD_PRE: ba_d = BA_MAX_W'(arb_idx);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CKE_LOW;
      rrd_cnt_q <= '0;
      ccd_cnt_q <= '0;
      wtr_cnt_q <= '0;
      rtw_cnt_q <= '0;
      enc_q     <= ENC_NOP;
      ba_q      <= '0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      rrd_cnt_q <= rrd_cnt_d;
      ccd_cnt_q <= ccd_cnt_d;
      wtr_cnt_q <= wtr_cnt_d;
      rtw_cnt_q <= rtw_cnt_d;
      enc_q     <= enc_d;
      ba_q      <= ba_d;
      addr_q    <= addr_d;
    end
  end

  assign bus.dfi_cke   = cke_q;
  assign bus.dfi_cs_n  = {CS_W{NOP_CS_N}};
  assign bus.dfi_ras_n = enc_q[2];
  assign bus.dfi_cas_n = enc_q[1];
  assign bus.dfi_we_n  = enc_q[0];
  assign bus.dfi_ba    = ba_q;
  assign bus.dfi_addr  = addr_q;

`ifdef SAL_DFI_ODT_EN
  logic [2:0] odt_cnt_q, odt_cnt_d;

  // Count 5 covers the WR command cycle on DFI plus the 4 burst cycles after it.
  always_comb begin
    odt_cnt_d = (odt_cnt_q != 3'd0) ? odt_cnt_q - 3'd1 : 3'd0;
    if (gnt_cmd == CMD_WR) odt_cnt_d = 3'd5;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      odt_cnt_q <= 3'd0;
    end else begin
      odt_cnt_q <= odt_cnt_d;
    end
  end

  assign bus.dfi_odt = (odt_cnt_q != 3'd0);
`else
  assign bus.dfi_odt = 1'b0;
`endif

endmodule

// File: tb/tb_sal_cmd_sched.sv
// tb/tb_sal_cmd_sched.sv - random and directed checks of sal_cmd_sched against a cycle-stamp model
module tb_sal_cmd_sched;
  import sal_sched_pkg::*;

  localparam int NB = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [T_RRD_W-1:0] t_rrd = '0;
  logic [T_CCD_W-1:0] t_ccd = '0;
  logic [T_WTR_W-1:0] t_wtr = '0;
  logic [T_RTW_W-1:0] t_rtw = '0;

  sal_cmd_sched_if #(.NUM_BANKS(NB)) bus ();

  sal_cmd_sched #(.NUM_BANKS(NB), .BA_W(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .t_rrd (t_rrd),
    .t_ccd (t_ccd),
    .t_wtr (t_wtr),
    .t_rtw (t_rtw),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int n = 0;

  // Model: earliest cycle at which each timing class may issue again.
  bit cke_m = 1'b0;
  int last_m = NB - 1;
  int act_ok = 0, ccd_ok = 0, wtr_ok = 0, rtw_ok = 0, odt_until = -1;
  logic [2:0]          exp_enc = 3'b111;
  logic [BA_MAX_W-1:0] exp_ba = '0;
  logic [ADDR_W-1:0]   exp_addr = '0;

  logic [NB-1:0]       cap_act, cap_rd, cap_wr, cap_pre, cap_ref;
  logic [2:0]          cap_enc;
  logic [BA_MAX_W-1:0] cap_ba;
  logic [ADDR_W-1:0]   cap_addr;
  logic                cap_cke, cap_odt, cap_cs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  function automatic int tmax1(input int t);
    return (t == 0) ? 1 : t;
  endfunction

  // 1=RD 2=WR 3=ACT 4=PRE 0=none, by bank priority
  function automatic int bank_cls(input int b);
    if (bus.rd_req[b])  return 1;
    if (bus.wr_req[b])  return 2;
    if (bus.act_req[b]) return 3;
    if (bus.pre_req[b]) return 4;
    return 0;
  endfunction

  function automatic bit cls_ok(input int cls);
    case (cls)
      1:       return (n >= ccd_ok) && (n >= wtr_ok);
      2:       return (n >= ccd_ok) && (n >= rtw_ok);
      3:       return (n >= act_ok);
      4:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic sample();
    logic [NB-1:0]       e_act, e_rd, e_wr, e_pre, e_ref;
    logic [2:0]          nenc;
    logic [BA_MAX_W-1:0] nba;
    logic [ADDR_W-1:0]   naddr;
    int                  pick, b;
    bit                  exp_odt;
    @(negedge clk);
    cap_act = bus.act_gnt; cap_rd = bus.rd_gnt; cap_wr = bus.wr_gnt;
    cap_pre = bus.pre_gnt; cap_ref = bus.ref_gnt;
    cap_enc = {bus.dfi_ras_n, bus.dfi_cas_n, bus.dfi_we_n};
    cap_ba = bus.dfi_ba; cap_addr = bus.dfi_addr;
    cap_cke = bus.dfi_cke; cap_odt = bus.dfi_odt; cap_cs = bus.dfi_cs_n[0];
    e_act = '0; e_rd = '0; e_wr = '0; e_pre = '0; e_ref = '0;
    nenc = 3'b111; nba = '0; naddr = '0;
    if (rst) begin
      chk("rst_cke", cap_cke, 0);
      chk("rst_cmd", cap_enc, 3'b111);
      chk("rst_odt", cap_odt, 0);
      chk("rst_gnt", {cap_act, cap_rd, cap_wr, cap_pre}, 0);
      chk("rst_ref", cap_ref, 0);
      cke_m = 1'b0; last_m = NB - 1;
      act_ok = 0; ccd_ok = 0; wtr_ok = 0; rtw_ok = 0; odt_until = -1;
    end else begin
      exp_odt = 1'b0;
`ifdef SAL_DFI_ODT_EN
      exp_odt = (n <= odt_until);
`endif
      chk("dfi_cke", cap_cke, cke_m);
      chk("dfi_cmd", cap_enc, exp_enc);
      chk("dfi_ba", cap_ba, exp_ba);
      chk("dfi_addr", cap_addr, exp_addr);
      chk("dfi_cs_n", cap_cs, 0);
      chk("dfi_odt", cap_odt, exp_odt);
      if (cke_m) begin
        if (&bus.ref_req) begin
          e_ref = '1;
          nenc = 3'b001;
        end else begin
          pick = -1;
          for (int i = 1; i <= NB && pick < 0; i++) begin
            b = (last_m + i) % NB;
            if (cls_ok(bank_cls(b))) pick = b;
          end
          if (pick >= 0) begin
            case (bank_cls(pick))
              1: begin
                e_rd[pick] = 1'b1; nenc = 3'b101;
                naddr = ADDR_W'(bus.ca[pick]); naddr[10] = 1'b0;
                ccd_ok = n + tmax1(int'(t_ccd)); rtw_ok = n + tmax1(int'(t_rtw));
              end
              2: begin
                e_wr[pick] = 1'b1; nenc = 3'b100;
                naddr = ADDR_W'(bus.ca[pick]); naddr[10] = 1'b0;
                ccd_ok = n + tmax1(int'(t_ccd)); wtr_ok = n + tmax1(int'(t_wtr));
                odt_until = n + 5;
              end
              3: begin
                e_act[pick] = 1'b1; nenc = 3'b011;
                naddr = ADDR_W'(bus.ra[pick]);
                act_ok = n + tmax1(int'(t_rrd));
              end
              default: begin
                e_pre[pick] = 1'b1; nenc = 3'b010;
              end
            endcase
            nba = BA_MAX_W'(pick);
            last_m = pick;
          end
        end
      end
      chk("act_gnt", cap_act, e_act);
      chk("rd_gnt", cap_rd, e_rd);
      chk("wr_gnt", cap_wr, e_wr);
      chk("pre_gnt", cap_pre, e_pre);
      chk("ref_gnt", cap_ref, e_ref);
      cke_m = 1'b1;
    end
    exp_enc = nenc; exp_ba = nba; exp_addr = naddr;
    n++;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    adv();
  endtask

  task automatic clear_reqs();
    bus.act_req = '0; bus.rd_req = '0; bus.wr_req = '0;
    bus.pre_req = '0; bus.ref_req = '0;
  endtask

  // Leaves the bench at the first cycle where CKE is high.
  task automatic do_reset();
    clear_reqs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    logic [NB-1:0] held;
    int            first;
    int            seq [3];
    bit            exp_o;
    seq = '{0, 3, 5};
    clear_reqs();
    bus.ra = '0; bus.ca = '0;
    t_rrd = 1; t_ccd = 1; t_wtr = 1; t_rtw = 1;

    // ACT on banks 0 and 1 together with t_rrd=4
    do_reset();
    t_rrd = 4;
    bus.ra[1] = 14'h1A5;
    held = 8'h03;
    for (int c = 0; c < 6; c++) begin
      bus.act_req = held;
      sample();
      if (c == 0) chk("s1_gnt_c0", cap_act, 8'h01);
      if (c >= 1 && c <= 3) chk("s1_wait", cap_act, 8'h00);
      if (c == 4) chk("s1_gnt_c4", cap_act, 8'h02);
      if (c == 5) begin
        chk("s1_dfi_cmd", cap_enc, 3'b011);
        chk("s1_dfi_ba", cap_ba, 1);
        chk("s1_dfi_addr", cap_addr, 14'h1A5);
      end
      held = held & ~cap_act;
      adv();
    end
    clear_reqs();

    // WR then RD on bank 2 with t_ccd=2, t_wtr=6
    do_reset();
    t_rrd = 1; t_ccd = 2; t_wtr = 6;
    bus.ca[2] = 10'h155;
    bus.wr_req = 8'h04;
    sample();
    chk("s2_wr_gnt", cap_wr, 8'h04);
    adv();
    bus.wr_req = 8'h00;
    held = 8'h04;
    first = -1;
    for (int c = 1; c < 9; c++) begin
      bus.rd_req = held;
      sample();
      if (c == 1) chk("s2_dfi_wr", cap_enc, 3'b100);
      if (first < 0 && cap_rd != 0) first = c;
      if (c == 7) begin
        chk("s2_dfi_rd", cap_enc, 3'b101);
        chk("s2_dfi_addr", cap_addr, 14'h155);
      end
      held = held & ~cap_rd;
      adv();
    end
    chk("s2_rd_cycle", first, 6);
    clear_reqs();

    // Banks 0, 3, 5 hold RD continuously
    do_reset();
    t_ccd = 1; t_wtr = 1;
    bus.rd_req = 8'b0010_1001;
    for (int k = 0; k < 9; k++) begin
      sample();
      chk("s3_rr", cap_rd, 8'h01 << seq[k % 3]);
      adv();
    end
    clear_reqs();

    // All banks request REF while bank 4 requests ACT
    do_reset();
    bus.ref_req = 8'hFF;
    bus.act_req = 8'h10;
    sample();
    chk("s4_ref_gnt", cap_ref, 8'hFF);
    chk("s4_act_held", cap_act, 8'h00);
    adv();
    bus.ref_req = 8'h00;
    sample();
    chk("s4_dfi_ref", cap_enc, 3'b001);
    chk("s4_dfi_ba", cap_ba, 0);
    chk("s4_act_after", cap_act, 8'h10);
    adv();
    clear_reqs();

    // Reset pulse while rrd counter is 3
    do_reset();
    t_rrd = 4;
    bus.act_req = 8'h01;
    sample();
    chk("s5_act0", cap_act, 8'h01);
    adv();
    bus.act_req = 8'h02;
    sample();
    chk("s5_act_blocked", cap_act, 8'h00);
    #2 rst = 1'b1;
    #1;
    chk("s5_cke_async", bus.dfi_cke, 0);
    chk("s5_nop_async", {bus.dfi_ras_n, bus.dfi_cas_n, bus.dfi_we_n}, 3'b111);
    adv();
    step();
    rst = 1'b0;
    sample();
    chk("s5_cke_low", cap_cke, 0);
    chk("s5_no_gnt", cap_act, 8'h00);
    adv();
    sample();
    chk("s5_cke_high", cap_cke, 1);
    chk("s5_act_now", cap_act, 8'h02);
    adv();
    clear_reqs();

    // ODT window around a WR at cycle 10
    do_reset();
    t_rrd = 1; t_ccd = 1; t_wtr = 1; t_rtw = 1;
    for (int c = 0; c < 18; c++) begin
      bus.wr_req = (c == 10) ? 8'h02 : 8'h00;
      sample();
      exp_o = 1'b0;
`ifdef SAL_DFI_ODT_EN
      exp_o = (c >= 11 && c <= 15);
`endif
      chk("s6_odt", cap_odt, exp_o);
      adv();
    end
    clear_reqs();

    // Random traffic, timings and occasional resets
    for (int k = 0; k < 3000; k++) begin
      if (k % 250 == 0) begin
        t_rrd = T_RRD_W'($urandom_range(0, 7));
        t_ccd = T_CCD_W'($urandom_range(0, 4));
        t_wtr = T_WTR_W'($urandom_range(0, 7));
        t_rtw = T_RTW_W'($urandom_range(0, 7));
      end
      rst = ($urandom_range(0, 299) == 0);
      bus.act_req = NB'($urandom & $urandom);
      bus.rd_req  = NB'($urandom & $urandom & $urandom);
      bus.wr_req  = NB'($urandom & $urandom & $urandom);
      bus.pre_req = NB'($urandom & $urandom);
      bus.ref_req = ($urandom_range(0, 15) == 0) ? 8'hFF : NB'($urandom & $urandom);
      for (int b = 0; b < NB; b++) begin
        bus.ra[b] = RA_W'($urandom);
        bus.ca[b] = CA_W'($urandom);
      end
      step();
    end
    rst = 1'b0;
    clear_reqs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
